// File: rtl/response_encoder.sv
// response_encoder: serializes an opcode byte plus payload bytes (MSB first)
// into strobed single-byte transfers, tracking each byte through tx_busy.
module response_encoder #(
   parameter int PAYLOAD_BYTES = 4,
   parameter int ACK_TIMEOUT   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        send,
   input  logic [7:0]  opcode,
   input  logic [31:0] payload,
   input  logic        tx_busy,
   output logic [7:0]  byte_out,
   output logic        byte_out_valid,
   output logic        busy,
   output logic        done,
   output logic        error
);
   localparam int         PW   = 8 * PAYLOAD_BYTES;
   localparam logic [2:0] LAST = 3'(PAYLOAD_BYTES);
   localparam logic [7:0] TMAX = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      EMIT      = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_DONE = 3'd3,
      DONE      = 3'd4,
      ERROR     = 3'd5
   } state_t;

   state_t      state;
   logic [39:0] shift;
   logic [2:0]  count;
   logic [7:0]  timer;
   logic [31:0] payload_aligned;

   // used payload bytes pushed up against the opcode; shifted-in low bytes are zero
   assign payload_aligned = payload << (32 - PW);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         shift          <= '0;
         count          <= '0;
         timer          <= '0;
         byte_out       <= '0;
         byte_out_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         byte_out_valid <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         case (state)
            IDLE: begin
               if (send) begin
                  shift <= {opcode, payload_aligned};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= EMIT;
               end
            end
            EMIT: begin
               if (!tx_busy) begin
                  byte_out       <= shift[39:32];
                  byte_out_valid <= 1'b1;
                  timer          <= '0;
                  state          <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               // an ack arriving on the expiry cycle still wins
               if (tx_busy)
                  state <= WAIT_DONE;
               else if (timer == TMAX)
                  state <= ERROR;
               else
                  timer <= timer + 8'd1;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (count == LAST) begin
                     state <= DONE;
                  end else begin
                     shift <= {shift[31:0], 8'h00};
                     count <= count + 3'd1;
                     state <= EMIT;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERROR: begin
               error <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
